// File: rtl/mole_pkg.sv
// mole_pkg: shared types and helpers for the mole round scheduler.
//   state_e      - round sequencer states
//   BOX_NONE     - box code meaning "no box lit"
//   rand_to_box  - maps a 3-bit random sample onto a box number 1..4
//   sat_inc8     - 8-bit saturating add of a small increment
package mole_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GAP    = 3'd1,
        PICK   = 3'd2,
        SHOW   = 3'd3,
        RESULT = 3'd4,
        DONE   = 3'd5
    } state_e;

    localparam logic [2:0] BOX_NONE = 3'd0;

    // Uneven table: box 1 takes three codes, box 2 one, boxes 3 and 4 two each.
    function automatic logic [2:0] rand_to_box(input logic [2:0] r);
        logic [2:0] b;
        case (r)
            3'd0, 3'd1, 3'd2: b = 3'd1;
            3'd3:             b = 3'd2;
            3'd4, 3'd5:       b = 3'd3;
            default:          b = 3'd4;
        endcase
        return b;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic [1:0] n);
        logic [8:0] s;
        s = {1'b0, v} + {7'b0, n};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/mole_timer.sv
// mole_timer: loadable down-counter shared by the GAP and SHOW phases.
//   clk, rst_n   - clock, asynchronous active-low reset
//   load_i       - load load_val_i (takes priority over counting)
//   load_val_i   - number of cycles the phase lasts (>= 1)
//   en_i         - count while high
//   expire_o     - high during the last cycle of the loaded period
module mole_timer #(
    parameter int CNT_W = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q;

    // Loaded with N, the count reads N on the first cycle of the phase and
    // 1 on the N-th, which is the cycle flagged as expiry.
    assign expire_o = en_i && (cnt_q <= CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q > CNT_W'(1))) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/mole_round_scheduler.sv
// mole_round_scheduler: sequences one round of the box-hitting game.
//   CLOCK_50     - clock (rising edge)
//   resetn       - asynchronous active-low reset
//   start        - begins a round from IDLE or DONE
//   rand_in      - random sample, consumed in the cycle rand_en is high
//   rand_en      - advance request to the random source
//   hit_valid    - player strike strobe, hit_box = struck box
//   box_active   - lit box (0 = none), box_onehot = its one-hot form
//   score/misses - saturating hit / miss counters
//   mole_idx     - moles completed this round
//   busy / done  - round in progress / round finished
// Optional build macro: DIFFICULTY_RAMP_EN shortens the SHOW window by
// ON_CYCLES/16 after every correct hit, floored at ON_CYCLES/4.
module mole_round_scheduler
    import mole_pkg::*;
#(
    parameter int NUM_BOXES  = 4,
    parameter int ON_CYCLES  = 25_000_000,
    parameter int GAP_CYCLES = 12_500_000,
    parameter int ROUND_LEN  = 20,
    parameter int CNT_W      = 25
) (
    input  logic                 CLOCK_50,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [2:0]           rand_in,
    output logic                 rand_en,
    input  logic                 hit_valid,
    input  logic [2:0]           hit_box,
    output logic [2:0]           box_active,
    output logic [NUM_BOXES-1:0] box_onehot,
    output logic [7:0]           score,
    output logic [7:0]           misses,
    output logic [4:0]           mole_idx,
    output logic                 busy,
    output logic                 done
);

    localparam logic [CNT_W-1:0] ON_C  = CNT_W'(ON_CYCLES);
    localparam logic [CNT_W-1:0] GAP_C = CNT_W'(GAP_CYCLES);
    localparam logic [2:0]       NB3   = 3'(NUM_BOXES);
    localparam logic [4:0]       LAST  = 5'(ROUND_LEN);

    state_e     state_q, state_d;
    logic [2:0] box_q, box_d;
    logic [2:0] prev_q, prev_d;
    logic [7:0] score_q, score_d;
    logic [7:0] misses_q, misses_d;
    logic [4:0] idx_q, idx_d;

    logic             timer_load, timer_en, timer_exp;
    logic [CNT_W-1:0] timer_val;
    logic [CNT_W-1:0] window;
    logic             start_acc, hit_ok, hit_bad;
    logic [2:0]       mapped, picked;

    mole_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (CLOCK_50),
        .rst_n      (resetn),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .en_i       (timer_en),
        .expire_o   (timer_exp)
    );

    assign timer_en  = (state_q == GAP) || (state_q == SHOW);
    assign start_acc = start && ((state_q == IDLE) || (state_q == DONE));
    assign hit_ok    = (state_q == SHOW) && hit_valid && (hit_box == box_q);
    assign hit_bad   = (state_q == SHOW) && hit_valid && (hit_box != box_q);

    // Never light the same box twice in a row: step to the next box, wrapping.
    assign mapped = rand_to_box(rand_in);
    assign picked = (mapped != prev_q) ? mapped
                  : ((mapped == NB3) ? 3'd1 : mapped + 3'd1);

`ifdef DIFFICULTY_RAMP_EN
    localparam logic [CNT_W-1:0] RAMP_STEP  = CNT_W'(ON_CYCLES / 16);
    localparam logic [CNT_W-1:0] RAMP_FLOOR = CNT_W'(ON_CYCLES / 4);

    logic [CNT_W-1:0] window_q, window_d;

    always_comb begin
        window_d = window_q;
        if (start_acc) begin
            window_d = ON_C;
        end else if (hit_ok) begin
            window_d = (window_q >= RAMP_FLOOR + RAMP_STEP) ? window_q - RAMP_STEP
                                                            : RAMP_FLOOR;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            window_q <= ON_C;
        end else begin
            window_q <= window_d;
        end
    end

    assign window = window_q;
`else
    assign window = ON_C;
`endif

    always_comb begin
        state_d    = state_q;
        box_d      = box_q;
        prev_d     = prev_q;
        score_d    = score_q;
        misses_d   = misses_q;
        idx_d      = idx_q;
        timer_load = 1'b0;
        timer_val  = GAP_C;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = GAP;
                    score_d    = 8'd0;
                    misses_d   = 8'd0;
                    idx_d      = 5'd0;
                    timer_load = 1'b1;
                end
            end
            GAP: begin
                if (timer_exp) begin
                    state_d = PICK;
                end
            end
            PICK: begin
                box_d      = picked;
                state_d    = SHOW;
                timer_load = 1'b1;
                timer_val  = window;
            end
            SHOW: begin
                if (hit_ok) begin
                    // A correct hit on the expiry cycle still counts as a hit.
                    score_d = sat_inc8(score_q, 2'd1);
                    state_d = RESULT;
                end else begin
                    // A wrong hit on the expiry cycle is charged as well as the timeout.
                    misses_d = sat_inc8(misses_q, {1'b0, hit_bad} + {1'b0, timer_exp});
                    if (timer_exp) begin
                        state_d = RESULT;
                    end
                end
            end
            RESULT: begin
                box_d  = BOX_NONE;
                prev_d = box_q;
                idx_d  = idx_q + 5'd1;
                if (idx_q + 5'd1 == LAST) begin
                    state_d = DONE;
                end else begin
                    state_d    = GAP;
                    timer_load = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            box_q    <= BOX_NONE;
            prev_q   <= BOX_NONE;
            score_q  <= 8'd0;
            misses_q <= 8'd0;
            idx_q    <= 5'd0;
        end else begin
            state_q  <= state_d;
            box_q    <= box_d;
            prev_q   <= prev_d;
            score_q  <= score_d;
            misses_q <= misses_d;
            idx_q    <= idx_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BOXES; gi++) begin : g_onehot
            assign box_onehot[gi] = (box_q == 3'(gi + 1));
        end
    endgenerate

    assign rand_en    = (state_q == PICK);
    assign box_active = box_q;
    assign score      = score_q;
    assign misses     = misses_q;
    assign mole_idx   = idx_q;
    assign busy       = (state_q != IDLE) && (state_q != DONE);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_mole_round_scheduler.sv
// Directed bench for mole_round_scheduler with a phase-level reference model.
module tb_mole_round_scheduler;

    localparam int NB  = 4;
    localparam int ON  = 8;
    localparam int GP  = 4;
    localparam int RL  = 3;

    logic          clk = 1'b0;
    logic          resetn = 1'b1;
    logic          start = 1'b0;
    logic [2:0]    rand_in = 3'd0;
    logic          rand_en;
    logic          hit_valid = 1'b0;
    logic [2:0]    hit_box = 3'd0;
    logic [2:0]    box_active;
    logic [NB-1:0] box_onehot;
    logic [7:0]    score, misses;
    logic [4:0]    mole_idx;
    logic          busy, done;

    int errors = 0;
    int checks = 0;

    mole_round_scheduler #(
        .NUM_BOXES (NB),
        .ON_CYCLES (ON),
        .GAP_CYCLES(GP),
        .ROUND_LEN (RL),
        .CNT_W     (4)
    ) dut (
        .CLOCK_50  (clk),
        .resetn    (resetn),
        .start     (start),
        .rand_in   (rand_in),
        .rand_en   (rand_en),
        .hit_valid (hit_valid),
        .hit_box   (hit_box),
        .box_active(box_active),
        .box_onehot(box_onehot),
        .score     (score),
        .misses    (misses),
        .mole_idx  (mole_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (phases with elapsed-cycle counts) ----
    localparam int P_IDLE = 0, P_GAP = 1, P_PICK = 2, P_SHOW = 3, P_RES = 4, P_DONE = 5;

    int m_phase = P_IDLE;
    int m_el    = 0;
    int m_box   = 0;
    int m_prev  = 0;
    int m_score = 0;
    int m_miss  = 0;
    int m_idx   = 0;

    function automatic int model_pick(input int r, input int prev);
        int tbl [8] = '{1, 1, 1, 2, 3, 3, 4, 4};
        int b;
        b = tbl[r];
        if (b == prev) b = (b % NB) + 1;
        return b;
    endfunction

    function automatic int sat255(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_phase <= P_IDLE; m_el <= 0; m_box <= 0; m_prev <= 0;
            m_score <= 0; m_miss <= 0; m_idx <= 0;
        end else begin
            case (m_phase)
                P_IDLE, P_DONE: if (start) begin
                    m_phase <= P_GAP; m_el <= 1;
                    m_score <= 0; m_miss <= 0; m_idx <= 0;
                end
                P_GAP: if (m_el == GP) m_phase <= P_PICK; else m_el <= m_el + 1;
                P_PICK: begin
                    m_box <= model_pick(int'(rand_in), m_prev);
                    m_phase <= P_SHOW; m_el <= 1;
                end
                P_SHOW: begin
                    if (hit_valid && int'(hit_box) == m_box) begin
                        m_score <= sat255(m_score + 1);
                        m_phase <= P_RES;
                    end else begin
                        m_miss <= sat255(m_miss + (hit_valid ? 1 : 0) + (m_el == ON ? 1 : 0));
                        if (m_el == ON) m_phase <= P_RES; else m_el <= m_el + 1;
                    end
                end
                P_RES: begin
                    m_prev <= m_box; m_box <= 0; m_idx <= m_idx + 1;
                    m_phase <= (m_idx + 1 == RL) ? P_DONE : P_GAP; m_el <= 1;
                end
                default: m_phase <= P_IDLE;
            endcase
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        check("cmp_box_active", int'(box_active), m_box);
        check("cmp_box_onehot", int'(box_onehot), (m_box == 0) ? 0 : (1 << (m_box - 1)));
        check("cmp_score", int'(score), m_score);
        check("cmp_misses", int'(misses), m_miss);
        check("cmp_mole_idx", int'(mole_idx), m_idx);
        check("cmp_rand_en", int'(rand_en), (m_phase == P_PICK) ? 1 : 0);
        check("cmp_busy", int'(busy), (m_phase != P_IDLE && m_phase != P_DONE) ? 1 : 0);
        check("cmp_done", int'(done), (m_phase == P_DONE) ? 1 : 0);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_pick();
        int found;
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            tick();
            if (rand_en) found = 1;
        end
        check("pick_timeout", found, 1);
    endtask

    task automatic pulse_hit(input logic [2:0] b);
        hit_valid = 1'b1;
        hit_box   = b;
        tick();
        hit_valid = 1'b0;
    endtask

    initial begin
        #2 resetn = 1'b0;
        tick();
        tick();
        check("reset_box", int'(box_active), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_score", int'(score), 0);
        resetn = 1'b1;
        tick();

        // Round 1, mole 1: rand 3 -> box 2, hit in SHOW cycle 3
        rand_in = 3'd3;
        pulse_start();
        check("start_busy", int'(busy), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("gap_rand_en_low", int'(rand_en), 0);
        end
        tick();
        check("gap4_rand_en", int'(rand_en), 1);
        tick();
        check("r1m1_box", int'(box_active), 2);
        check("r1m1_onehot", int'(box_onehot), 2);
        tick();
        tick();
        pulse_hit(3'd2);
        check("r1m1_score", int'(score), 1);
        tick();
        check("r1m1_box_clear", int'(box_active), 0);
        check("r1m1_idx", int'(mole_idx), 1);

        // Mole 2: rand 4 -> box 3, wrong hit then timeout
        rand_in = 3'd4;
        wait_pick();
        tick();
        check("r1m2_box", int'(box_active), 3);
        pulse_hit(3'd1);
        check("r1m2_wrong_miss", int'(misses), 1);
        check("r1m2_still_show", int'(box_active), 3);
        for (int i = 0; i < 7; i++) tick();
        check("r1m2_timeout_miss", int'(misses), 2);
        tick();
        check("r1m2_idx", int'(mole_idx), 2);

        // Mole 3: rand 0 -> box 1, immediate hit, round ends
        rand_in = 3'd0;
        wait_pick();
        tick();
        check("r1m3_box", int'(box_active), 1);
        pulse_hit(3'd1);
        check("r1m3_score", int'(score), 2);
        tick();
        check("r1_done", int'(done), 1);
        check("r1_busy", int'(busy), 0);
        check("r1_idx", int'(mole_idx), 3);
        pulse_hit(3'd2);
        tick();
        check("r1_hold_score", int'(score), 2);
        check("r1_hold_misses", int'(misses), 2);

        // Round 2: restart clears counters; start and hit during GAP ignored
        rand_in = 3'd6;
        pulse_start();
        check("r2_score_clr", int'(score), 0);
        check("r2_misses_clr", int'(misses), 0);
        check("r2_idx_clr", int'(mole_idx), 0);
        start = 1'b1;
        pulse_hit(3'd4);
        start = 1'b0;
        wait_pick();
        tick();
        check("r2m1_box", int'(box_active), 4);
        for (int i = 0; i < 8; i++) tick();
        check("r2m1_timeout_miss", int'(misses), 1);
        tick();

        // Mole 2: rand 7 -> 4 repeats previous box 4 -> box 1; hit on expiry
        rand_in = 3'd7;
        wait_pick();
        tick();
        check("r2m2_norepeat_box", int'(box_active), 1);
        for (int i = 0; i < 7; i++) tick();
        pulse_hit(3'd1);
        check("r2m2_expiry_score", int'(score), 1);
        check("r2m2_expiry_misses", int'(misses), 1);
        tick();
        check("r2m2_idx", int'(mole_idx), 2);

        // Mole 3: rand 5 -> box 3, asynchronous reset mid-SHOW
        rand_in = 3'd5;
        wait_pick();
        tick();
        check("r2m3_box", int'(box_active), 3);
        tick();
        #2 resetn = 1'b0;
        #1;
        check("async_box", int'(box_active), 0);
        check("async_onehot", int'(box_onehot), 0);
        check("async_score", int'(score), 0);
        check("async_misses", int'(misses), 0);
        check("async_idx", int'(mole_idx), 0);
        check("async_busy", int'(busy), 0);
        tick();
        tick();
        resetn = 1'b1;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mole_round_scheduler.md
Name: mole_round_scheduler

Overview:
- Sequences one game round of the box-hitting game.
- Draws a random box from the 3-bit random source, lights it for a bounded window and judges player hits.
- Counts score and misses, then repeats for a fixed number of moles.
- Sits between the random-address generator and the display/score logic; it is the only consumer of the random source.

Parameters:
- NUM_BOXES, 4, number of target boxes; boxes are encoded 1..NUM_BOXES, and 0 means none.
- ON_CYCLES, 25_000_000, clock cycles a box stays lit.
- GAP_CYCLES, 12_500_000, dark cycles between moles.
- ROUND_LEN, 20, moles per round.
- CNT_W, 25, width of the cycle timer; must hold max(ON_CYCLES, GAP_CYCLES).

Ports:
- CLOCK_50  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a round; ignored unless the block is in IDLE or DONE.
- rand_in  in  3  current random value.
- rand_en  out  1  one-cycle pulse asking the source to advance; the value is consumed in the same cycle.
- hit_valid  in  1  single-cycle strobe: the player struck a box.
- hit_box  in  3  box struck (1..NUM_BOXES); qualified by hit_valid.
- box_active  out  3  box currently lit (0 = none).
- box_onehot  out  NUM_BOXES  one-hot of box_active; bit k is box k+1.
- score  out  8  hits this round; saturates at 255.
- misses  out  8  timeouts plus wrong hits; saturates at 255.
- mole_idx  out  5  moles completed this round.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE.

Behaviour:
- Reset: every output is 0; state is IDLE; the previous-box register is 0.
- States and transitions:
  - IDLE: on start, go to GAP. score, misses and mole_idx clear in the same cycle.
  - GAP: run GAP_CYCLES cycles, then go to PICK.
  - PICK: exactly one cycle.
    - rand_en=1; sample rand_in.
    - Map the sample to a box: 0→1, 1→1, 2→1, 3→2, 4→3, 5→3, 6→4, 7→4.
    - If the mapped box equals the previous box, use (box mod NUM_BOXES)+1 instead.
    - Register the result in box_active; go to SHOW.
  - SHOW:
    - Timer runs ON_CYCLES cycles; the first SHOW cycle is cycle 1.
    - hit_valid with hit_box==box_active: score+1 and go to RESULT.
    - hit_valid with a different box: misses+1; stay in SHOW; the timer is not reset.
    - Timer expires with no hit: misses+1 and go to RESULT.
    - Hit and expiry in the same cycle: the hit wins; score+1 only.
  - RESULT: one cycle.
    - box_active←0; previous box←the box just shown; mole_idx+1.
    - If mole_idx+1==ROUND_LEN, go to DONE, otherwise go to GAP.
  - DONE: hold score, misses and mole_idx. On start, clear them and go to GAP (same as IDLE).
- Latency: box_active becomes valid on the clock edge after the PICK cycle. That is GAP_CYCLES+1 cycles after start is accepted.
- box_onehot is combinational from box_active.
- hit_valid outside SHOW is ignored; no counter changes.
- Counters saturate and do not wrap.
- Timers are reloaded on every state entry.
- Reset mid-round: all outputs return to their reset values immediately (asynchronous). No partial score is retained.
- start while busy is ignored.

Optional Feature:
- Macro: DIFFICULTY_RAMP_EN.
- When defined:
  - Each correct hit shortens the next SHOW window by ON_CYCLES/16.
  - The window never goes below ON_CYCLES/4.
  - The window is restored to ON_CYCLES on start.
- When undefined: every SHOW window is exactly ON_CYCLES, and no ramp register is synthesized.

Decomposition:
- Package mole_pkg holds:
  - the state enum: IDLE, GAP, PICK, SHOW, RESULT, DONE;
  - the constant BOX_NONE=3'd0;
  - a function that maps a 3-bit random value to a box.
- Natural sub-module: mole_timer, a loadable down-counter with load, enable and an expire flag. The GAP and SHOW phases share one instance.

Test Plan:
All scenarios use ON_CYCLES=8, GAP_CYCLES=4 and ROUND_LEN=3.
- Reset release then start pulse:
  - busy=1 next cycle;
  - rand_en pulses 4 cycles after entering GAP;
  - box_active≠0 on the following edge;
  - box_onehot matches.
- rand_in=3 at PICK, previous box 0:
  - box_active=2;
  - a hit on box 2 in SHOW cycle 3 → score=1, box_active=0 one cycle later.
- No-repeat rule: previous box=4, rand_in=7 → box_active=1.
- Wrong box: hit_box=1 while box 3 is lit → misses=1, still in SHOW; then timeout → misses=2, mole_idx=1.
- Hit in the same cycle as timer expiry (SHOW cycle 8) → score+1, misses unchanged.
- Round end and reset:
  - Three moles complete → done=1, busy=0, values held.
  - start → score=0 next cycle.
  - Deassert resetn mid-SHOW → all outputs 0 immediately.
